// File: rtl/egress_drr_scheduler.sv
// Deficit-round-robin egress scheduler: shares one link among NUM_QUEUES codel
// instances with a one-hot, zero-latency link-ready grant per cycle.
module egress_drr_scheduler #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned QUANTUM    = 1518,
  parameter int unsigned DEF_W      = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i__link_ready,
  input  logic [NUM_QUEUES-1:0]         i__q_nonempty,
  input  logic [NUM_QUEUES*LEN_W-1:0]   i__q_head_len,
  input  logic [NUM_QUEUES-1:0]         i__q_drop,
  output logic [NUM_QUEUES-1:0]         o__q_grant,
  output logic                          o__grant_valid,
  output logic [$clog2(NUM_QUEUES)-1:0] o__grant_idx,
  output logic                          o__busy
);

  localparam int unsigned PTR_W = $clog2(NUM_QUEUES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_SERVE  = 2'd2;

  localparam logic [DEF_W-1:0] DEF_MAX     = {DEF_W{1'b1}};
  localparam logic [DEF_W:0]   QUANTUM_EXT = (DEF_W+1)'(QUANTUM);

  logic [1:0]       r__state;
  logic [1:0]       state_nxt;
  logic [PTR_W-1:0] r__ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [DEF_W-1:0] r__deficit [NUM_QUEUES];

  logic             def_wr_en;
  logic [DEF_W-1:0] def_wr_val;
  logic [LEN_W-1:0] head_len [NUM_QUEUES];
  logic [DEF_W-1:0] cur_len;
  logic [DEF_W-1:0] cur_def;
  logic [DEF_W:0]   refill_sum;
  logic [DEF_W-1:0] refill_sat;
  logic             any_nonempty;
  logic             grant_ok;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_len
    assign head_len[q] = i__q_head_len[q*LEN_W +: LEN_W];
  end

  // Pointer-queue view; refill add is one bit wider so it can saturate.
  assign cur_len      = DEF_W'(head_len[r__ptr]);
  assign cur_def      = r__deficit[r__ptr];
  assign refill_sum   = {1'b0, cur_def} + QUANTUM_EXT;
  assign refill_sat   = refill_sum[DEF_W] ? DEF_MAX : refill_sum[DEF_W-1:0];
  assign any_nonempty = |i__q_nonempty;
  assign grant_ok     = (r__state == ST_SERVE) && i__link_ready &&
                        i__q_nonempty[r__ptr] && (cur_def >= cur_len);

  // Next-state, pointer and single deficit write (always at the pointer queue).
  always_comb begin
    state_nxt  = r__state;
    ptr_nxt    = r__ptr;
    def_wr_en  = 1'b0;
    def_wr_val = cur_def;
    case (r__state)
      ST_IDLE: begin
        if (any_nonempty) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        def_wr_en = 1'b1;
        if (i__q_nonempty[r__ptr]) begin
          def_wr_val = refill_sat;
          state_nxt  = ST_SERVE;
        end else begin
          def_wr_val = '0;
          ptr_nxt    = r__ptr + PTR_W'(1);
          state_nxt  = any_nonempty ? ST_REFILL : ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (grant_ok) begin
          // Dropped packets never reach the link, so they cost nothing.
          if (!i__q_drop[r__ptr]) begin
            def_wr_en  = 1'b1;
            def_wr_val = cur_def - cur_len;
          end
        end else if (!i__q_nonempty[r__ptr]) begin
          def_wr_en  = 1'b1;
          def_wr_val = '0;
          ptr_nxt    = r__ptr + PTR_W'(1);
          state_nxt  = ST_REFILL;
        end else if (cur_def < cur_len) begin
          ptr_nxt   = r__ptr + PTR_W'(1);
          state_nxt = ST_REFILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r__state <= ST_IDLE;
      r__ptr   <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) r__deficit[q] <= '0;
    end else begin
      r__state <= state_nxt;
      r__ptr   <= ptr_nxt;
      if (def_wr_en) r__deficit[r__ptr] <= def_wr_val;
    end
  end

  // Grant is combinational so codel can read its head on the same cycle.
  always_comb begin
    o__q_grant = '0;
    if (!reset) o__q_grant[r__ptr] = grant_ok;
  end

  assign o__grant_valid = |o__q_grant;
  assign o__grant_idx   = reset ? '0 : r__ptr;
  assign o__busy        = !reset && (r__state != ST_IDLE);

endmodule

// File: tb/tb_egress_drr_scheduler.sv
// Directed bench for egress_drr_scheduler: cycle-by-cycle vector table plus
// idle, fairness and reset sequences with hand-computed expectations.
module tb_egress_drr_scheduler;

  localparam int unsigned NQ = 4;
  localparam int unsigned LW = 11;

  logic            clk;
  logic            reset;
  logic            link_ready;
  logic [NQ-1:0]   q_nonempty;
  logic [NQ*LW-1:0] q_head_len;
  logic [NQ-1:0]   q_drop;
  logic [NQ-1:0]   q_grant;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic            busy;

  int n_tests;
  int n_fail;

  egress_drr_scheduler #(
    .NUM_QUEUES(NQ), .LEN_W(LW), .QUANTUM(1518), .DEF_W(12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i__link_ready (link_ready),
    .i__q_nonempty (q_nonempty),
    .i__q_head_len (q_head_len),
    .i__q_drop     (q_drop),
    .o__q_grant    (q_grant),
    .o__grant_valid(grant_valid),
    .o__grant_idx  (grant_idx),
    .o__busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [3:0]  ne;
    logic [3:0]  drop;
    logic [43:0] lens;
    logic [3:0]  eg;
    logic        eb;
    logic [1:0]  ei;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [43:0] lens(input int l0, input int l1, input int l2, input int l3);
    return {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic [3:0] ne,
                              input logic [3:0] drop, input logic [43:0] l,
                              input logic [3:0] eg, input logic eb, input logic [1:0] ei);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ne = ne; v.drop = drop; v.lens = l;
    v.eg = eg; v.eb = eb; v.ei = ei;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] eg, input logic eb,
                           input logic [1:0] ei);
    n_tests++;
    if (q_grant !== eg || grant_valid !== (|eg) || busy !== eb || grant_idx !== ei) begin
      n_fail++;
      $display("FAIL %s: got grant=%b valid=%b busy=%b idx=%0d, expected grant=%b valid=%b busy=%b idx=%0d",
               name, q_grant, grant_valid, busy, grant_idx, eg, |eg, eb, ei);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  logic [43:0] la, lb, lc, ld;
  int b0, b1, multi, cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; link_ready = 1'b1; q_nonempty = '1; q_head_len = '0; q_drop = '0;

    la = lens(0, 1000, 0, 0);
    lb = lens(800, 1000, 0, 0);
    lc = lens(800, 0, 618, 0);
    ld = lens(800, 0, 1000, 0);

    // single queue q1 len 1000: skip q0, refill 1518, one grant, re-serve with 2036
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,0,0));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,0));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0010,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,2));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,3));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,0));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0010,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0010,1,1));
    vecs.push_back(mk(0,1,4'b0010,0,la,4'b0000,1,1));
    // drop not charged: q0 len 800, first grant dropped, second charged (718 left)
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,2));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,3));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,0));
    vecs.push_back(mk(0,1,4'b0001,4'b0001,lb,4'b0001,1,0));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0001,1,0));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,0));
    // backpressure: q0 refilled to 2236, link stalls 5 cycles, then two grants
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,2));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,3));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,4'b0001,0,lb,4'b0000,1,0));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0001,1,0));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0001,1,0));
    vecs.push_back(mk(0,1,4'b0001,0,lb,4'b0000,1,0));
    // reset mid-SERVE with q2 deficit 900; afterwards q2 refills from 0 (one 1000B grant only)
    vecs.push_back(mk(0,1,4'b0100,0,lc,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0100,0,lc,4'b0000,1,2));
    vecs.push_back(mk(0,1,4'b0100,0,lc,4'b0100,1,2));
    vecs.push_back(mk(1,1,4'b0100,0,ld,4'b0000,0,0));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0000,0,0));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0000,1,0));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0000,1,1));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0000,1,2));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0100,1,2));
    vecs.push_back(mk(0,1,4'b0100,0,ld,4'b0000,1,2));

    // reset with all queues nonempty: outputs must stay low
    tick();
    tick();
    #4;
    check_out("reset_hold", 4'b0000, 1'b0, 2'd0);
    tick();

    // idle for 20 cycles
    reset = 1'b0;
    q_nonempty = '0;
    for (int k = 0; k < 20; k++) begin
      #4;
      check_out($sformatf("idle[%0d]", k), 4'b0000, 1'b0, 2'd0);
      tick();
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      link_ready = vecs[i].rdy;
      q_nonempty = vecs[i].ne;
      q_drop     = vecs[i].drop;
      q_head_len = vecs[i].lens;
      #4;
      check_out($sformatf("vec[%0d]", i), vecs[i].eg, vecs[i].eb, vecs[i].ei);
      tick();
    end

    // fairness: q0 len 1500 vs q1 len 500, both always backlogged
    reset = 1'b1; q_nonempty = '0; q_drop = '0; link_ready = 1'b1;
    tick();
    reset = 1'b0;
    q_nonempty = 4'b0011;
    q_head_len = lens(1500, 500, 0, 0);
    b0 = 0; b1 = 0; multi = 0; cyc = 0;
    while (cyc < 2000 && (b0 + b1) < 12000) begin
      #4;
      if ($countones(q_grant) > 1 || q_grant[3:2] != 2'b00) multi++;
      if (q_grant[0]) b0 += 1500;
      if (q_grant[1]) b1 += 500;
      cyc++;
      tick();
    end
    check_true("fair_budget", (b0 + b1) >= 12000, b0 + b1, 12000);
    check_true("fair_onehot", multi == 0, multi, 0);
    check_true("fair_q0_served", b0 > 0, b0, 1);
    check_true("fair_q1_served", b1 > 0, b1, 1);
    check_true("fair_share", (b0 > b1 ? b0 - b1 : b1 - b0) <= 1518,
               b0 > b1 ? b0 - b1 : b1 - b0, 1518);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
